// File: rtl/fir_serial_mac.sv
// fir_serial_mac: serial multiply-accumulate FIR stage.
// A start pulse snapshots the packed tap vector, then one shared multiplier
// accumulates tap[k]*coef[k] over TOTAL_TAPS cycles. The accumulator is
// arithmetically shifted right by SHIFT and emitted with a one-cycle valid.
// Optional build macro: FIR_SATURATE_EN (clamp the scaled result to the
// OUT_BITS signed range instead of wrapping it).
module fir_serial_mac #(
    parameter int TOTAL_TAPS   = 9,
    parameter int BITS_PER_TAP = 8,
    parameter int TOTAL_BITS   = TOTAL_TAPS * BITS_PER_TAP,
    parameter int COEF_BITS    = 8,
    parameter logic [TOTAL_TAPS*COEF_BITS-1:0] COEFFS = {TOTAL_TAPS{8'sd16}},
    parameter int SHIFT        = 4,
    parameter int OUT_BITS     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start_calc,
    input  logic [TOTAL_BITS-1:0]      i_taps,
    output logic signed [OUT_BITS-1:0] o_value,
    output logic                       o_valid,
    output logic                       o_busy,
    output logic                       o_dropped
);

    localparam int IDX_BITS  = (TOTAL_TAPS > 1) ? $clog2(TOTAL_TAPS) : 1;
    localparam int PROD_BITS = BITS_PER_TAP + COEF_BITS;
    localparam int ACC_BITS  = BITS_PER_TAP + COEF_BITS + $clog2(TOTAL_TAPS);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(TOTAL_TAPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    state_t                       state;
    logic [TOTAL_BITS-1:0]        snapshot;
    logic signed [ACC_BITS-1:0]   acc;
    logic [IDX_BITS-1:0]          idx;

    logic signed [BITS_PER_TAP-1:0] tap_arr  [TOTAL_TAPS];
    logic signed [COEF_BITS-1:0]    coef_arr [TOTAL_TAPS];
    logic signed [BITS_PER_TAP-1:0] tap_cur;
    logic signed [COEF_BITS-1:0]    coef_cur;
    logic signed [PROD_BITS-1:0]    product;
    logic signed [OUT_BITS-1:0]     out_next;

    // Unpack the captured taps and the constant coefficients into indexable arrays
    for (genvar k = 0; k < TOTAL_TAPS; k++) begin : g_unpack
        assign tap_arr[k]  = snapshot[k*BITS_PER_TAP +: BITS_PER_TAP];
        assign coef_arr[k] = COEFFS[k*COEF_BITS +: COEF_BITS];
    end

    // The single shared multiplier works on the tap/coefficient pair selected by idx
    assign tap_cur  = tap_arr[idx];
    assign coef_cur = coef_arr[idx];
    assign product  = PROD_BITS'(tap_cur) * PROD_BITS'(coef_cur);

`ifdef FIR_SATURATE_EN
    localparam logic signed [ACC_BITS-1:0] OUT_MAX = ACC_BITS'((64'sd1 <<< (OUT_BITS - 1)) - 64'sd1);
    localparam logic signed [ACC_BITS-1:0] OUT_MIN = ACC_BITS'(-(64'sd1 <<< (OUT_BITS - 1)));

    logic signed [ACC_BITS-1:0] scaled;

    // Scale the accumulator and clamp it into the signed output range
    always_comb begin
        scaled   = acc >>> SHIFT;
        out_next = scaled[OUT_BITS-1:0];
        if (scaled > OUT_MAX) begin
            out_next = OUT_MAX[OUT_BITS-1:0];
        end else if (scaled < OUT_MIN) begin
            out_next = OUT_MIN[OUT_BITS-1:0];
        end
    end
`else
    // Scale the accumulator and keep only the low bits (two's-complement wrap)
    always_comb begin
        out_next = OUT_BITS'(acc >>> SHIFT);
    end
`endif

    // Control FSM: capture on start, accumulate one product per cycle, then publish
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            snapshot  <= '0;
            acc       <= '0;
            idx       <= '0;
            o_value   <= '0;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
            o_dropped <= 1'b0;
        end else begin
            o_valid   <= 1'b0;
            o_dropped <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start_calc) begin
                        snapshot <= i_taps;
                        acc      <= '0;
                        idx      <= '0;
                        o_busy   <= 1'b1;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_BITS'(product);
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end
                    if (i_start_calc) begin
                        o_dropped <= 1'b1;
                    end
                end
                DONE: begin
                    o_value <= out_next;
                    o_valid <= 1'b1;
                    o_busy  <= 1'b0;
                    state   <= IDLE;
                    if (i_start_calc) begin
                        o_dropped <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_serial_mac.sv
// tb_fir_serial_mac: directed testbench for fir_serial_mac with default
// parameters (coef=16, SHIFT=4, so each result equals the sum of the taps).
// Honours FIR_SATURATE_EN for the overflow vector.
module tb_fir_serial_mac;

    logic               clk;
    logic               rst;
    logic               i_start_calc;
    logic [71:0]        i_taps;
    logic signed [7:0]  o_value;
    logic               o_valid;
    logic               o_busy;
    logic               o_dropped;

    int checks;
    int failures;

    fir_serial_mac dut (
        .clk          (clk),
        .rst          (rst),
        .i_start_calc (i_start_calc),
        .i_taps       (i_taps),
        .o_value      (o_value),
        .o_valid      (o_valid),
        .o_busy       (o_busy),
        .o_dropped    (o_dropped)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic [71:0] allTaps(input logic [7:0] v);
        return {9{v}};
    endfunction

    // Pulse start for one cycle with the given taps, then scramble the bus.
    // Returns at the negedge just after the capture edge.
    task automatic applyStimulus(input logic [71:0] taps);
        @(negedge clk);
        i_taps       = taps;
        i_start_calc = 1'b1;
        @(negedge clk);
        i_start_calc = 1'b0;
        i_taps       = {$urandom, $urandom, $urandom};
    endtask

    // Wait (bounded) for o_valid, checking latency, busy length, value and pulse width
    task automatic waitResult(input string tag, input int exp_value);
        int lat;
        int busy_cnt;
        lat      = 0;
        busy_cnt = o_busy ? 1 : 0;
        while (!o_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (o_busy) busy_cnt++;
        end
        checkOutput({tag, "_latency"}, lat, 10);
        checkOutput({tag, "_busy_cycles"}, busy_cnt, 10);
        checkOutput({tag, "_value"}, int'(o_value), exp_value);
        @(negedge clk);
        checkOutput({tag, "_valid_pulse"}, int'(o_valid), 0);
        checkOutput({tag, "_hold_value"}, int'(o_value), exp_value);
    endtask

    initial begin
        logic [2:0] seen;
        int valid_cnt;
        int drop_cnt;
        int last_val;

        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        i_start_calc = 1'b0;
        i_taps       = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and quiet idle
        seen = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen |= {o_valid, o_busy, o_dropped};
        end
        checkOutput("idle_flags", int'(seen), 0);
        checkOutput("idle_value", int'(o_value), 0);

        // Single nonzero tap 0
        applyStimulus({64'd0, 8'sd5});
        waitResult("tap0_5", 5);

        // All taps 10
        applyStimulus(allTaps(8'sd10));
        waitResult("all_10", 90);

        // All taps -3
        applyStimulus(allTaps(-8'sd3));
        waitResult("all_m3", -27);

        // Overflow: sum 900
        applyStimulus(allTaps(8'sd100));
`ifdef FIR_SATURATE_EN
        waitResult("all_100", 127);
`else
        waitResult("all_100", -124);
`endif

        // Mixed taps: 1,2,...,9 with tap 4 negated -> 45 - 10 = 35
        applyStimulus({8'sd9, 8'sd8, 8'sd7, 8'sd6, -8'sd5, 8'sd4, 8'sd3, 8'sd2, 8'sd1});
        waitResult("mixed", 35);

        // Second start while busy is dropped, first result survives
        applyStimulus(allTaps(8'sd1));
        valid_cnt = 0;
        drop_cnt  = 0;
        last_val  = 0;
        repeat (2) @(negedge clk);
        i_taps       = allTaps(8'sd10);
        i_start_calc = 1'b1;
        @(negedge clk);
        i_start_calc = 1'b0;
        checkOutput("drop_pulse", int'(o_dropped), 1);
        drop_cnt += int'(o_dropped);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drop_cnt += int'(o_dropped);
            if (o_valid) begin
                valid_cnt++;
                last_val = int'(o_value);
            end
        end
        checkOutput("drop_count", drop_cnt, 1);
        checkOutput("drop_valid_count", valid_cnt, 1);
        checkOutput("drop_value", last_val, 9);

        // Reset mid-calculation aborts; start during reset ignored
        applyStimulus(allTaps(8'sd20));
        repeat (3) @(negedge clk);
        rst          = 1'b1;
        i_start_calc = 1'b1;
        i_taps       = allTaps(8'sd7);
        @(negedge clk);
        i_start_calc = 1'b0;
        checkOutput("rst_outputs", int'({o_valid, o_busy, o_dropped}), 0);
        checkOutput("rst_value", int'(o_value), 0);
        @(negedge clk);
        rst = 1'b0;
        seen = '0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            seen |= {o_valid, o_busy, o_dropped};
        end
        checkOutput("post_rst_flags", int'(seen), 0);
        checkOutput("post_rst_value", int'(o_value), 0);

        // Fresh calculation after reset
        applyStimulus(allTaps(8'sd10));
        waitResult("after_rst", 90);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
